// File: rtl/sabr_mul_pipe_if.sv
// sabr_mul_pipe_if: operand/result bundle for the SABR pipelined multiplier.
//   ce                 pipeline clock enable (0 freezes every stage)
//   in_valid/in_signed operand qualifier and per-op signed mode
//   in_tag, din0, din1 sideband tag and operands
//   out_valid/out_tag  result qualifier and returned tag
//   dout               scaled product
// master = operand producer, slave = the multiplier.
interface sabr_mul_pipe_if #(
  parameter int DIN0_WIDTH = 43,
  parameter int DIN1_WIDTH = 36,
  parameter int DOUT_WIDTH = 79,
  parameter int TAG_WIDTH  = 8
);
  logic                  ce;
  logic                  in_valid;
  logic                  in_signed;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [DOUT_WIDTH-1:0] dout;

  modport master (
    output ce, in_valid, in_signed, in_tag, din0, din1,
    input  out_valid, out_tag, dout
  );

  modport slave (
    input  ce, in_valid, in_signed, in_tag, din0, din1,
    output out_valid, out_tag, dout
  );
endinterface

// File: rtl/sabr_mul_pipe.sv
// sabr_mul_pipe: parametrised pipelined integer multiplier for the SABR
// datapath, with per-op signed/unsigned mode, a tag carried alongside each
// op, and a fixed right shift (SHIFT) applied to the full product.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, wins over ce
//   bus    sabr_mul_pipe_if.slave (ce, in_valid, in_signed, in_tag, din0,
//          din1 -> out_valid, out_tag, dout)
//
// Latency is NUM_STAGE (1..8) ce-qualified edges. Stage 1 registers the
// operands; the multiply/shift sits between stage 1 and stage 2, and any
// further stages just delay the result. With NUM_STAGE=1 the arithmetic is
// done ahead of the single register instead.
//
// Build option: define SABR_MUL_ROUND_EN to round half up before the shift
// (only has an effect when SHIFT>0). Latency is the same in both builds.
module sabr_mul_pipe #(
  parameter int DIN0_WIDTH = 43,
  parameter int DIN1_WIDTH = 36,
  parameter int DOUT_WIDTH = 79,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 0,
  parameter int TAG_WIDTH  = 8
) (
  input logic           clk,
  input logic           reset,
  sabr_mul_pipe_if.slave bus
);
  localparam int P  = DIN0_WIDTH + DIN1_WIDTH;
  // Wide enough to hold the rounded product with its carry plus a full
  // DOUT_WIDTH of sign/zero extension, so every step below is exact.
  localparam int EW = P + 1 + DOUT_WIDTH;

`ifdef SABR_MUL_ROUND_EN
  // 2^(SHIFT-1) for SHIFT>0, zero for SHIFT=0.
  localparam logic [EW-1:0] RND = ({{(EW-1){1'b0}}, 1'b1} << SHIFT) >> 1;
`else
  localparam logic [EW-1:0] RND = '0;
`endif

  function automatic logic [DOUT_WIDTH-1:0] scale(
    input logic [DIN0_WIDTH-1:0] a,
    input logic [DIN1_WIDTH-1:0] b,
    input logic                  sgn
  );
    logic [P-1:0]  ea, eb, prod;
    logic [EW-1:0] ext;
    ea = sgn ? {{DIN1_WIDTH{a[DIN0_WIDTH-1]}}, a} : {{DIN1_WIDTH{1'b0}}, a};
    eb = sgn ? {{DIN0_WIDTH{b[DIN1_WIDTH-1]}}, b} : {{DIN0_WIDTH{1'b0}}, b};
    // Low P bits of the product of the extended operands are exact for
    // both modes.
    prod = ea * eb;
    ext  = sgn ? {{(EW-P){prod[P-1]}}, prod} : {{(EW-P){1'b0}}, prod};
    ext  = ext + RND;
    // Separate branches keep the arithmetic shift in a signed context.
    if (sgn) scale = DOUT_WIDTH'($signed(ext) >>> SHIFT);
    else     scale = DOUT_WIDTH'(ext >> SHIFT);
  endfunction

  // Valid and tag travel the full depth; index k is stage k.
  logic [NUM_STAGE:1]                vld_pipe;
  logic [NUM_STAGE:1][TAG_WIDTH-1:0] tag_pipe;
  logic [DOUT_WIDTH-1:0]             dout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else if (bus.ce) begin
      vld_pipe[1] <= bus.in_valid;
      tag_pipe[1] <= bus.in_tag;
      for (int k = 2; k <= NUM_STAGE; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end
    end
  end

  generate
    if (NUM_STAGE == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (reset)       dout_q <= '0;
        else if (bus.ce) dout_q <= scale(bus.din0, bus.din1, bus.in_signed);
      end
    end else begin : g_multi
      logic [DIN0_WIDTH-1:0]              a_q;
      logic [DIN1_WIDTH-1:0]              b_q;
      logic                               sgn_q;
      logic [NUM_STAGE:2][DOUT_WIDTH-1:0] res_pipe;

      // Data registers follow the inputs even on bubbles; out_valid
      // qualifies them.
      always_ff @(posedge clk) begin
        if (reset) begin
          a_q      <= '0;
          b_q      <= '0;
          sgn_q    <= 1'b0;
          res_pipe <= '0;
        end else if (bus.ce) begin
          a_q         <= bus.din0;
          b_q         <= bus.din1;
          sgn_q       <= bus.in_signed;
          res_pipe[2] <= scale(a_q, b_q, sgn_q);
          for (int k = 3; k <= NUM_STAGE; k++)
            res_pipe[k] <= res_pipe[k-1];
        end
      end

      assign dout_q = res_pipe[NUM_STAGE];
    end
  endgenerate

  // Outputs come straight from the last stage registers.
  assign bus.out_valid = vld_pipe[NUM_STAGE];
  assign bus.out_tag   = tag_pipe[NUM_STAGE];
  assign bus.dout      = dout_q;
endmodule

// File: tb/tb_sabr_mul_pipe.sv
// tb_sabr_mul_pipe: directed bench for sabr_mul_pipe. u_dut uses the default
// parameters; u_sh uses SHIFT=4 and follows the SABR_MUL_ROUND_EN build.
module tb_sabr_mul_pipe;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sabr_mul_pipe_if #(.DIN0_WIDTH(43), .DIN1_WIDTH(36), .DOUT_WIDTH(79), .TAG_WIDTH(8)) bus ();
  sabr_mul_pipe_if #(.DIN0_WIDTH(43), .DIN1_WIDTH(36), .DOUT_WIDTH(79), .TAG_WIDTH(8)) sbus ();

  sabr_mul_pipe #(.DIN0_WIDTH(43), .DIN1_WIDTH(36), .DOUT_WIDTH(79),
                  .NUM_STAGE(2), .SHIFT(0), .TAG_WIDTH(8))
    u_dut (.clk(clk), .reset(reset), .bus(bus));

  sabr_mul_pipe #(.DIN0_WIDTH(43), .DIN1_WIDTH(36), .DOUT_WIDTH(79),
                  .NUM_STAGE(2), .SHIFT(4), .TAG_WIDTH(8))
    u_sh (.clk(clk), .reset(reset), .bus(sbus));

  typedef struct {
    bit          sh;
    logic        sgn;
    logic [42:0] a;
    logic [35:0] b;
    logic [7:0]  tag;
    logic [78:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [78:0] act, input logic [78:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sgn, input logic [42:0] a,
                       input logic [35:0] b, input logic [7:0] tag);
    bus.in_valid = v; bus.in_signed = sgn; bus.din0 = a; bus.din1 = b; bus.in_tag = tag;
  endtask

  task automatic check_out(input string name, input logic v, input logic [78:0] d,
                           input logic [7:0] tag);
    chk({name, ".valid"}, 79'(bus.out_valid), 79'(v));
    if (v) begin
      chk({name, ".dout"}, bus.dout, d);
      chk({name, ".tag"}, 79'(bus.out_tag), 79'(tag));
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.sh) begin
      sbus.in_valid = 1'b1; sbus.in_signed = v.sgn; sbus.din0 = v.a;
      sbus.din1 = v.b; sbus.in_tag = v.tag;
    end else begin
      drive(1'b1, v.sgn, v.a, v.b, v.tag);
    end
    tick();
    bus.in_valid = 1'b0; sbus.in_valid = 1'b0;
    chk("vec.early_valid", 79'(v.sh ? sbus.out_valid : bus.out_valid), 79'(0));
    tick();
    chk("vec.valid", 79'(v.sh ? sbus.out_valid : bus.out_valid), 79'(1));
    chk("vec.dout", v.sh ? sbus.dout : bus.dout, v.exp);
    chk("vec.tag", 79'(v.sh ? sbus.out_tag : bus.out_tag), 79'(v.tag));
    tick();
    chk("vec.late_valid", 79'(v.sh ? sbus.out_valid : bus.out_valid), 79'(0));
  endtask

  vec_t vt[13];

  initial begin
    // {sh, sgn, a, b, tag, expected}
    vt[0]  = '{0, 0, 43'd3, 36'd5, 8'hA5, 79'd15};
    vt[1]  = '{0, 1, 43'h7FF_FFFF_FFFF, 36'd2, 8'h01, 79'h7FFF_FFFF_FFFF_FFFF_FFFE};
    vt[2]  = '{0, 0, 43'h7FF_FFFF_FFFF, 36'd2, 8'h02, 79'h0FFF_FFFF_FFFE};
    vt[3]  = '{0, 0, 43'h7FF_FFFF_FFFF, 36'hF_FFFF_FFFF, 8'h03, 79'h7FFF_FFFF_F7F0_0000_0001};
    vt[4]  = '{0, 1, 43'h7FF_FFFF_FFFF, 36'hF_FFFF_FFFF, 8'h04, 79'd1};
    vt[5]  = '{0, 1, 43'h400_0000_0000, 36'h8_0000_0000, 8'h05, 79'h2000_0000_0000_0000_0000};
    vt[6]  = '{0, 1, 43'h7FF_FFFF_FFFD, 36'd5, 8'h06, 79'h7FFF_FFFF_FFFF_FFFF_FFF1};
    vt[7]  = '{0, 0, 43'd0, 36'hF_FFFF_FFFF, 8'hFF, 79'd0};
`ifdef SABR_MUL_ROUND_EN
    vt[8]  = '{1, 0, 43'd3, 36'd8, 8'h10, 79'd2};
    vt[9]  = '{1, 1, 43'h7FF_FFFF_FFFD, 36'd8, 8'h11, 79'h7FFF_FFFF_FFFF_FFFF_FFFF};
    vt[10] = '{1, 0, 43'd255, 36'd1, 8'h12, 79'd16};
    vt[11] = '{1, 1, 43'h7FF_FFFF_FFF8, 36'd1, 8'h13, 79'd0};
    vt[12] = '{1, 0, 43'd7, 36'd1, 8'h14, 79'd0};
`else
    vt[8]  = '{1, 0, 43'd3, 36'd8, 8'h10, 79'd1};
    vt[9]  = '{1, 1, 43'h7FF_FFFF_FFFD, 36'd8, 8'h11, 79'h7FFF_FFFF_FFFF_FFFF_FFFE};
    vt[10] = '{1, 0, 43'd255, 36'd1, 8'h12, 79'd15};
    vt[11] = '{1, 1, 43'h7FF_FFFF_FFF8, 36'd1, 8'h13, 79'h7FFF_FFFF_FFFF_FFFF_FFFF};
    vt[12] = '{1, 0, 43'd7, 36'd1, 8'h14, 79'd0};
`endif

    reset = 1'b1;
    bus.ce = 1'b1; sbus.ce = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    sbus.in_valid = 1'b0; sbus.in_signed = 1'b0; sbus.din0 = '0; sbus.din1 = '0; sbus.in_tag = '0;
    tick();
    chk("rst.valid", 79'(bus.out_valid), 79'(0));
    chk("rst.dout", bus.dout, 79'(0));
    chk("rst.tag", 79'(bus.out_tag), 79'(0));
    chk("rst.sh_valid", 79'(sbus.out_valid), 79'(0));
    tick();
    reset = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Back-to-back: same operands, signed then unsigned, consecutive results.
    drive(1'b1, 1'b1, 43'h7FF_FFFF_FFFF, 36'd2, 8'h21);
    tick();
    drive(1'b1, 1'b0, 43'h7FF_FFFF_FFFF, 36'd2, 8'h22);
    tick();
    bus.in_valid = 1'b0;
    check_out("b2b.first", 1'b1, 79'h7FFF_FFFF_FFFF_FFFF_FFFE, 8'h21);
    tick();
    check_out("b2b.second", 1'b1, 79'h0FFF_FFFF_FFFE, 8'h22);
    tick();
    check_out("b2b.after", 1'b0, '0, '0);

    // Stall: tags 1,2,3; ce low for 3 cycles after the second accept.
    drive(1'b1, 1'b0, 43'd2, 36'd3, 8'd1);
    tick();
    drive(1'b1, 1'b0, 43'd4, 36'd5, 8'd2);
    tick();
    check_out("stall.t1", 1'b1, 79'd6, 8'd1);
    drive(1'b1, 1'b0, 43'd6, 36'd7, 8'd3);
    bus.ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall.frozen", 1'b1, 79'd6, 8'd1);
    end
    bus.ce = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check_out("stall.t2", 1'b1, 79'd20, 8'd2);
    tick();
    check_out("stall.t3", 1'b1, 79'd42, 8'd3);
    tick();
    check_out("stall.drain", 1'b0, '0, '0);

    // Reset while A is in flight and B is being presented.
    drive(1'b1, 1'b0, 43'd5, 36'd6, 8'h11);
    tick();
    check_out("rmid.pre", 1'b0, '0, '0);
    drive(1'b1, 1'b0, 43'd7, 36'd9, 8'h22);
    reset = 1'b1;
    tick();
    chk("rmid.valid", 79'(bus.out_valid), 79'(0));
    chk("rmid.dout", bus.dout, 79'(0));
    chk("rmid.tag", 79'(bus.out_tag), 79'(0));
    reset = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("rmid.gone", 1'b0, '0, '0);
    end
    drive(1'b1, 1'b0, 43'd9, 36'd9, 8'h33);
    tick();
    bus.in_valid = 1'b0;
    check_out("rmid.new_early", 1'b0, '0, '0);
    tick();
    check_out("rmid.new", 1'b1, 79'd81, 8'h33);
    tick();
    check_out("rmid.new_after", 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sabr_mul_pipe.md
Name: sabr_mul_pipe

Overview:
- Parametrised pipelined integer multiplier for the SABR datapath. It is the next generation of the fixed-width 2-cycle multiplier.
- Adds configurable widths and latency, a valid/tag side-channel carried through the pipe, per-transaction signed/unsigned mode, and a programmable fixed-point right shift on the product.
- Sits between the SABR path-update arithmetic and its accumulators. Stalls with the rest of the pipeline via ce.

Parameters:
- DIN0_WIDTH, 43, width of operand A
- DIN1_WIDTH, 36, width of operand B
- DOUT_WIDTH, 79, width of result
- NUM_STAGE, 2, pipeline latency in cycles; legal range 1..8
- SHIFT, 0, arithmetic right shift applied to the full product; legal range 0..(DIN0_WIDTH+DIN1_WIDTH-1)
- TAG_WIDTH, 8, width of the sideband tag carried alongside each operation

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; 0 freezes every pipeline stage
- in_valid  in  1  operands valid this cycle
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned
- in_tag  in  TAG_WIDTH  sideband, returned unchanged with the result
- din0  in  DIN0_WIDTH  operand A
- din1  in  DIN1_WIDTH  operand B
- out_valid  out  1  dout/out_tag valid
- out_tag  out  TAG_WIDTH  tag of the emerging result
- dout  out  DOUT_WIDTH  result

Behaviour:
- Full product width P = DIN0_WIDTH+DIN1_WIDTH.
  - in_signed=1: sign-extend both operands to P bits before multiplying.
  - in_signed=0: zero-extend both operands.
  - Product is exact in P bits.
- Scaling:
  - Shifted value S = product >>> SHIFT when in_signed=1, logical >> when in_signed=0.
  - dout = S[DOUT_WIDTH-1:0]. Bits above DOUT_WIDTH are discarded (wrap, no saturation).
  - If DOUT_WIDTH > P-SHIFT, the upper bits are sign-extended (signed) or zero-filled (unsigned).
- Pipeline:
  - NUM_STAGE register stages. Each stage holds {valid, signed, tag, data}.
  - Stage 1 captures inputs when ce=1. Stage k captures stage k-1 when ce=1.
  - Arithmetic may be split across stages freely, but the result must be cycle-exact to the above.
- Latency: an operation accepted on the edge with ce=1 and in_valid=1 appears at the outputs after exactly NUM_STAGE ce-qualified edges. Throughput is 1 per ce cycle.
- ce=0: all stages, including valid bits, hold their value. Outputs remain stable and out_valid does not pulse.
- in_valid=0 with ce=1: a bubble (valid=0) enters the pipe.
  - dout and out_tag are don't-care while out_valid=0.
  - Data registers still update, so no extra gating is needed.
- Reset:
  - Synchronous, and takes priority over ce.
  - All valid bits, dout, and out_tag go to 0 on the first edge with reset=1.
  - In-flight operations are discarded, including on reset mid-operation.
  - The first operation accepted on the edge after reset deasserts emerges NUM_STAGE cycles later.
- Outputs are driven directly from the last stage registers. No combinational input-to-output path exists.
- Back-to-back operations with differing in_signed or in_tag are each processed with their own mode and tag. There is no cross-contamination.

Optional Feature:
- Macro SABR_MUL_ROUND_EN.
- Defined, with SHIFT>0: round half up before shifting.
  - S = (product + 2^(SHIFT-1)) >> SHIFT, evaluated in P+1 bits.
  - Signed mode uses an arithmetic shift after the add.
  - A carry out of P bits is kept in S before truncation to DOUT_WIDTH.
- Not defined, or SHIFT=0: plain truncating shift as above.
- Latency is identical in both builds.

Test Plan:
- Defaults (43/36/79, NUM_STAGE=2, SHIFT=0). Inputs din0=3, din1=5, in_signed=0, in_tag=8'hA5, in_valid for 1 cycle, ce=1.
  - Expect out_valid=1 exactly 2 cycles later, with dout=15 and out_tag=8'hA5.
  - Expect out_valid=0 on all other cycles.
- Mode: din0=43'h7FF_FFFF_FFFF (all ones), din1=2.
  - in_signed=1 -> dout=79'h7FFF_FFFF_FFFF_FFFF_FFFE (-2).
  - Next cycle, in_signed=0, same operands -> dout=2^44-2.
  - The two results emerge on consecutive cycles.
- Max unsigned: din0=2^43-1, din1=2^36-1, in_signed=0 -> dout=2^79-2^43-2^36+1.
- Stall: stream tags 1,2,3 on consecutive cycles, then drop ce for 3 cycles after the 2nd accept.
  - Outputs freeze for those 3 cycles.
  - Tags emerge in order 1,2,3 with no duplicate or lost out_valid pulses.
- Reset mid-flight: accept 2 operations, assert reset for 1 cycle before either emerges.
  - Expect out_valid=0, dout=0, out_tag=0 after the reset edge.
  - Neither operation ever appears.
  - A new operation issued after reset emerges 2 cycles later.
- SHIFT=4, in_signed=0, din0=3, din1=8 (product 24).
  - Without SABR_MUL_ROUND_EN -> dout=1.
  - With SABR_MUL_ROUND_EN -> dout=2.
  - Also run signed din0=-3, din1=8 (product -24) -> truncate -2, round -1.
